// File: rtl/pwm_measure.sv
// pwm_measure: receive-side checker for a DPWM H/L output pair.
// Measures H on-time, H->L dead time, L on-time, L->H dead time and period
// per switching cycle, publishes them with a one-cycle strobe and flags
// overlap and edge-order violations.
// Optional macro PWM_SYNC_EN: adds a SYNC_STAGES-deep synchroniser on
// H_PWM and L_PWM for pins that are asynchronous to clk.
module pwm_measure #(
  parameter int unsigned Dc_length   = 13,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 meas_en,
  input  logic                 H_PWM,
  input  logic                 L_PWM,
  output logic [Dc_length-1:0] H_on_meas,
  output logic [Dc_length-1:0] DT_HL_meas,
  output logic [Dc_length-1:0] L_on_meas,
  output logic [Dc_length-1:0] DT_LH_meas,
  output logic [Dc_length+1:0] Period_meas,
  output logic                 meas_valid,
  output logic                 meas_sat,
  output logic                 overlap_err,
  output logic                 seq_err
);

  localparam int unsigned PW = Dc_length + 2;
  localparam logic [Dc_length-1:0] CNT_MAX = {Dc_length{1'b1}};
  localparam logic [Dc_length-1:0] CNT_ONE = Dc_length'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    H_ON  = 3'd1,
    DT_HL = 3'd2,
    L_ON  = 3'd3,
    DT_LH = 3'd4
  } state_t;

  state_t               state;
  logic                 h_in, l_in;
  logic                 s_h, p_h, s_l, p_l;
  logic [Dc_length-1:0] cnt;
  logic                 sat;
  logic [Dc_length-1:0] h_q, dthl_q, l_q;

  // A synchroniser depth of zero would leave the chain without an output
  if (SYNC_STAGES < 1) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 1");
  end

`ifdef PWM_SYNC_EN
  logic [SYNC_STAGES-1:0] h_sync, l_sync;

  // Synchroniser chains ahead of the sampling registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_sync <= '0;
      l_sync <= '0;
    end else begin
      h_sync[0] <= H_PWM;
      l_sync[0] <= L_PWM;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        h_sync[i] <= h_sync[i-1];
        l_sync[i] <= l_sync[i-1];
      end
    end
  end

  assign h_in = h_sync[SYNC_STAGES-1];
  assign l_in = l_sync[SYNC_STAGES-1];
`else
  assign h_in = H_PWM;
  assign l_in = L_PWM;
`endif

  logic h_rise, h_fall, l_rise, l_fall, overlap;
  assign h_rise  = s_h & ~p_h;
  assign h_fall  = ~s_h & p_h;
  assign l_rise  = s_l & ~p_l;
  assign l_fall  = ~s_l & p_l;
  assign overlap = s_h & s_l;

  // Saturating phase counter step
  logic                 cnt_at_max;
  logic [Dc_length-1:0] cnt_inc;
  assign cnt_at_max = (cnt == CNT_MAX);
  assign cnt_inc    = cnt_at_max ? cnt : cnt + CNT_ONE;

  // Closing H rise: from L_ON the L->H dead time is zero, from DT_LH it is cnt
  logic                 publish;
  logic [Dc_length-1:0] pub_l, pub_dtlh;
  logic [PW-1:0]        pub_period;
  assign publish    = meas_en & ~overlap & h_rise &
                      ((state == DT_LH) | ((state == L_ON) & l_fall));
  assign pub_l      = (state == L_ON) ? cnt : l_q;
  assign pub_dtlh   = (state == L_ON) ? '0 : cnt;
  assign pub_period = PW'(h_q) + PW'(dthl_q) + PW'(pub_l) + PW'(pub_dtlh);

  // Sampling, phase-sequence FSM, counter and registered results
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_h         <= 1'b0;
      p_h         <= 1'b0;
      s_l         <= 1'b0;
      p_l         <= 1'b0;
      state       <= IDLE;
      cnt         <= '0;
      sat         <= 1'b0;
      h_q         <= '0;
      dthl_q      <= '0;
      l_q         <= '0;
      H_on_meas   <= '0;
      DT_HL_meas  <= '0;
      L_on_meas   <= '0;
      DT_LH_meas  <= '0;
      Period_meas <= '0;
      meas_valid  <= 1'b0;
      meas_sat    <= 1'b0;
      overlap_err <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      s_h         <= h_in;
      p_h         <= s_h;
      s_l         <= l_in;
      p_l         <= s_l;
      meas_valid  <= 1'b0;
      overlap_err <= 1'b0;
      seq_err     <= 1'b0;

      if (!meas_en) begin
        state <= IDLE;
        cnt   <= '0;
        sat   <= 1'b0;
      end else if (overlap) begin
        overlap_err <= 1'b1;
        state       <= IDLE;
        cnt         <= '0;
        sat         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (h_rise) begin
              state <= H_ON;
              cnt   <= CNT_ONE;
            end
          end
          H_ON: begin
            if (h_fall) begin
              h_q <= cnt;
              cnt <= CNT_ONE;
              if (l_rise) begin
                dthl_q <= '0;
                state  <= L_ON;
              end else begin
                state  <= DT_HL;
              end
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end
          DT_HL: begin
            if (l_rise) begin
              dthl_q <= cnt;
              cnt    <= CNT_ONE;
              state  <= L_ON;
            end else if (h_rise) begin
              seq_err <= 1'b1;
              cnt     <= CNT_ONE;
              sat     <= 1'b0;
              state   <= H_ON;
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end
          L_ON: begin
            if (l_fall) begin
              l_q   <= cnt;
              cnt   <= CNT_ONE;
              state <= h_rise ? H_ON : DT_LH;
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end
          DT_LH: begin
            if (h_rise) begin
              cnt   <= CNT_ONE;
              state <= H_ON;
            end else if (l_rise) begin
              seq_err <= 1'b1;
              cnt     <= '0;
              sat     <= 1'b0;
              state   <= IDLE;
            end else begin
              cnt <= cnt_inc;
              sat <= sat | cnt_at_max;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
          end
        endcase

        if (publish) begin
          H_on_meas   <= h_q;
          DT_HL_meas  <= dthl_q;
          L_on_meas   <= pub_l;
          DT_LH_meas  <= pub_dtlh;
          Period_meas <= pub_period;
          meas_sat    <= sat;
          meas_valid  <= 1'b1;
          sat         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_measure.sv
// tb_pwm_measure: drives directed and randomized H/L waveforms into a 13-bit
// and a 4-bit instance and checks both against an edge-timestamp model.
module tb_pwm_measure;

  logic clk, rst, meas_en, H_PWM, L_PWM;

  logic [12:0] h13, dthl13, l13, dtlh13;
  logic [14:0] per13;
  logic        v13, sat13, ovl13, seq13;

  logic [3:0]  h4, dthl4, l4, dtlh4;
  logic [5:0]  per4;
  logic        v4, sat4, ovl4, seq4;

  pwm_measure u_dut13 (
    .clk(clk), .rst(rst), .meas_en(meas_en), .H_PWM(H_PWM), .L_PWM(L_PWM),
    .H_on_meas(h13), .DT_HL_meas(dthl13), .L_on_meas(l13), .DT_LH_meas(dtlh13),
    .Period_meas(per13), .meas_valid(v13), .meas_sat(sat13),
    .overlap_err(ovl13), .seq_err(seq13)
  );

  pwm_measure #(.Dc_length(4)) u_dut4 (
    .clk(clk), .rst(rst), .meas_en(meas_en), .H_PWM(H_PWM), .L_PWM(L_PWM),
    .H_on_meas(h4), .DT_HL_meas(dthl4), .L_on_meas(l4), .DT_LH_meas(dtlh4),
    .Period_meas(per4), .meas_valid(v4), .meas_sat(sat4),
    .overlap_err(ovl4), .seq_err(seq4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_err    = 0;
  int n_valid  = 0;
  int n_ovl    = 0;
  int n_seq    = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model keeps timestamps of the detected edges of the current period;
  // each phase is the distance between two timestamps, clipped to the
  // counter range of each instance (index 0: 13-bit, index 1: 4-bit).
  int  cyc = 0;
  bit  started = 0;
  bit  ms_h, ms_l, mp_h, mp_l;
  int  stage;
  int  t0, t1, t2, t3;
  int  e_h[2], e_dthl[2], e_l[2], e_dtlh[2], e_per[2], e_sat[2];
  int  e_valid, e_ovl, e_seq;

  task automatic model_publish(input int n);
    int r[4];
    int mx, c, sum, s;
    r[0] = t1 - t0;
    r[1] = t2 - t1;
    r[2] = t3 - t2;
    r[3] = n - t3;
    for (int w = 0; w < 2; w++) begin
      mx  = (w == 0) ? 8191 : 15;
      sum = 0;
      s   = 0;
      for (int k = 0; k < 4; k++) begin
        c = (r[k] > mx) ? mx : r[k];
        if (r[k] > mx) s = 1;
        sum += c;
        if (k == 0) e_h[w] = c;
        if (k == 1) e_dthl[w] = c;
        if (k == 2) e_l[w] = c;
        if (k == 3) e_dtlh[w] = c;
      end
      e_per[w] = sum;
      e_sat[w] = s;
    end
    e_valid = 1;
  endtask

  task automatic model_step();
    bit hr, hf, lr, lf;
    e_valid = 0;
    e_ovl   = 0;
    e_seq   = 0;
    if (!rst) begin
      for (int w = 0; w < 2; w++) begin
        e_h[w] = 0; e_dthl[w] = 0; e_l[w] = 0; e_dtlh[w] = 0;
        e_per[w] = 0; e_sat[w] = 0;
      end
      stage = 0;
      ms_h = 0; ms_l = 0; mp_h = 0; mp_l = 0;
    end else begin
      hr = ms_h && !mp_h;
      hf = !ms_h && mp_h;
      lr = ms_l && !mp_l;
      lf = !ms_l && mp_l;
      if (!meas_en) begin
        stage = 0;
      end else if (ms_h && ms_l) begin
        e_ovl = 1;
        stage = 0;
      end else begin
        case (stage)
          0: if (hr) begin t0 = cyc; stage = 1; end
          1: if (hf) begin
               t1 = cyc;
               if (lr) begin t2 = cyc; stage = 3; end
               else stage = 2;
             end
          2: if (lr) begin t2 = cyc; stage = 3; end
             else if (hr) begin e_seq = 1; t0 = cyc; stage = 1; end
          3: if (lf) begin
               t3 = cyc;
               if (hr) begin model_publish(cyc); t0 = cyc; stage = 1; end
               else stage = 4;
             end
          4: if (hr) begin model_publish(cyc); t0 = cyc; stage = 1; end
             else if (lr) begin e_seq = 1; stage = 0; end
          default: stage = 0;
        endcase
      end
      mp_h = ms_h;
      mp_l = ms_l;
      ms_h = H_PWM;
      ms_l = L_PWM;
    end
    cyc++;
    started = 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare process: every output of both instances on every cycle
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("d13_H_on",   32'(h13),    e_h[0]);
      chk("d13_DT_HL",  32'(dthl13), e_dthl[0]);
      chk("d13_L_on",   32'(l13),    e_l[0]);
      chk("d13_DT_LH",  32'(dtlh13), e_dtlh[0]);
      chk("d13_period", 32'(per13),  e_per[0]);
      chk("d13_sat",    32'(sat13),  e_sat[0]);
      chk("d13_valid",  32'(v13),    e_valid);
      chk("d13_ovl",    32'(ovl13),  e_ovl);
      chk("d13_seq",    32'(seq13),  e_seq);
      chk("d4_H_on",    32'(h4),     e_h[1]);
      chk("d4_DT_HL",   32'(dthl4),  e_dthl[1]);
      chk("d4_L_on",    32'(l4),     e_l[1]);
      chk("d4_DT_LH",   32'(dtlh4),  e_dtlh[1]);
      chk("d4_period",  32'(per4),   e_per[1]);
      chk("d4_sat",     32'(sat4),   e_sat[1]);
      chk("d4_valid",   32'(v4),     e_valid);
      chk("d4_ovl",     32'(ovl4),   e_ovl);
      chk("d4_seq",     32'(seq4),   e_seq);
      if (v13 === 1'b1) n_valid++;
      if (ovl13 === 1'b1) n_ovl++;
      if (seq13 === 1'b1) n_seq++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic seg(input bit h, input bit l, input int n);
    H_PWM = h;
    L_PWM = l;
    repeat (n) @(negedge clk);
  endtask

  task automatic restart();
    meas_en = 1'b0;
    H_PWM   = 1'b0;
    L_PWM   = 1'b0;
    repeat (2) @(negedge clk);
    meas_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    bit found;
    found = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (v13 === 1'b1) begin
        found = 1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_err++;
      $display("FAIL %s_timeout actual no_strobe required strobe", name);
    end
    #1;
  endtask

  task automatic chk_set(input string name, input int h, input int dthl,
                         input int l, input int dtlh, input int per);
    chk({name, "_H_on"},   32'(h13),    h);
    chk({name, "_DT_HL"},  32'(dthl13), dthl);
    chk({name, "_L_on"},   32'(l13),    l);
    chk({name, "_DT_LH"},  32'(dtlh13), dtlh);
    chk({name, "_period"}, 32'(per13),  per);
  endtask

  int v0, o0, s0;

  initial begin
    rst = 1'b0; meas_en = 1'b0; H_PWM = 1'b0; L_PWM = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_H_on",   32'(h13),   0);
    chk("rst_period", 32'(per13), 0);
    chk("rst_valid",  32'(v13),   0);
    rst = 1'b1;
    meas_en = 1'b1;
    seg(0, 0, 3);

    // Basic period 10/3/20/4
    seg(1, 0, 10); seg(0, 0, 3); seg(0, 1, 20); seg(0, 0, 4); seg(1, 0, 1);
    wait_valid("t1");
    chk_set("t1", 10, 3, 20, 4, 37);
    chk("t1_sat",     32'(sat13), 0);
    chk("t1_d4_L_on", 32'(l4),    15);
    chk("t1_d4_sat",  32'(sat4),  1);
    chk("t1_d4_per",  32'(per4),  32);
    @(negedge clk);
    chk("t1_valid_one_cycle", 32'(v13), 0);

    // H fall and L rise in the same cycle
    restart();
    s0 = n_seq; o0 = n_ovl;
    seg(1, 0, 6); seg(0, 1, 5); seg(0, 0, 2); seg(1, 0, 1);
    wait_valid("t2");
    chk_set("t2", 6, 0, 5, 2, 13);
    chk("t2_no_err", 32'(n_seq - s0 + n_ovl - o0), 0);

    // Overlap during L_ON, then a clean period
    restart();
    v0 = n_valid; o0 = n_ovl;
    seg(1, 0, 5); seg(0, 0, 2); seg(0, 1, 3); seg(1, 1, 1); seg(0, 1, 2); seg(0, 0, 2);
    seg(1, 0, 4); seg(0, 0, 1); seg(0, 1, 6); seg(0, 0, 2); seg(1, 0, 1);
    wait_valid("t3");
    chk_set("t3", 4, 1, 6, 2, 13);
    chk("t3_ovl_pulses",  32'(n_ovl - o0),   1);
    chk("t3_valid_count", 32'(n_valid - v0), 1);

    // H re-rises without an L pulse
    restart();
    v0 = n_valid; s0 = n_seq;
    seg(1, 0, 3); seg(0, 0, 2); seg(1, 0, 4); seg(0, 0, 1); seg(0, 1, 5); seg(0, 0, 2);
    seg(1, 0, 1);
    wait_valid("t4");
    chk_set("t4", 4, 1, 5, 2, 12);
    chk("t4_seq_pulses",  32'(n_seq - s0),   1);
    chk("t4_valid_count", 32'(n_valid - v0), 1);

    // Saturation in the 4-bit instance
    restart();
    seg(1, 0, 20); seg(0, 0, 2); seg(0, 1, 3); seg(0, 0, 2); seg(1, 0, 1);
    wait_valid("t5");
    chk("t5_d4_H_on",  32'(h4),    15);
    chk("t5_d4_sat",   32'(sat4),  1);
    chk("t5_d4_per",   32'(per4),  22);
    chk("t5_d13_H_on", 32'(h13),   20);
    chk("t5_d13_sat",  32'(sat13), 0);
    chk("t5_d13_per",  32'(per13), 27);

    // Reset mid L_ON
    restart();
    seg(1, 0, 5); seg(0, 0, 1); seg(0, 1, 3);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_set("t6_rst", 0, 0, 0, 0, 0);
    chk("t6_rst_sat", 32'(sat13), 0);
    rst = 1'b1;
    seg(0, 1, 2); seg(0, 0, 2);
    seg(1, 0, 7); seg(0, 0, 1); seg(0, 1, 2); seg(0, 0, 1); seg(1, 0, 1);
    wait_valid("t6a");
    chk_set("t6a", 7, 1, 2, 1, 11);

    // meas_en drop mid period: outputs hold, no strobe until a full new period
    seg(1, 0, 3);
    meas_en = 1'b0;
    seg(1, 0, 3);
    meas_en = 1'b1;
    v0 = n_valid;
    seg(1, 0, 2); seg(0, 0, 2); seg(0, 1, 3); seg(0, 0, 2); seg(1, 0, 4);
    chk("t6_en_no_strobe", 32'(n_valid - v0), 0);
    chk_set("t6_en_hold", 7, 1, 2, 1, 11);
    seg(0, 0, 1); seg(0, 1, 2); seg(0, 0, 3); seg(1, 0, 1);
    wait_valid("t6b");
    chk_set("t6b", 4, 1, 2, 3, 10);
    chk("t6b_valid_count", 32'(n_valid - v0), 1);

    // Randomized periods with occasional overlap, skipped L and enable drops
    restart();
    for (int it = 0; it < 150; it++) begin
      int hl, g1, ll, g2, anom;
      hl   = $urandom_range(1, 20);
      g1   = $urandom_range(0, 3);
      ll   = $urandom_range(1, 20);
      g2   = $urandom_range(0, 3);
      anom = $urandom_range(0, 7);
      meas_en = ($urandom_range(0, 14) != 0);
      seg(1, 0, hl);
      if (g1 > 0) seg(0, 0, g1);
      if (anom == 1) seg(1, 1, 1);
      if (anom != 2) begin
        seg(0, 1, ll);
        if (g2 > 0) seg(0, 0, g2);
      end
    end
    seg(0, 0, 4);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/pwm_measure.md
Name: pwm_measure

Overview:
- Receive-side checker for the HR_DPWM output pair.
- Samples H_PWM and L_PWM on the system clock and measures, per switching period in clk cycles: high on-time, high-to-low dead time, low on-time, low-to-high dead time and total period.
- Publishes one measurement set per period with a one-cycle valid strobe, and flags overlap or sequence violations.
- Closes the loop on the DPWM on-time and dead-time commands for bench self-check and on-chip monitoring.

Parameters:
- Dc_length, 13, width of each phase measurement; also the phase-counter width.
- SYNC_STAGES, 2, synchroniser depth on H_PWM and L_PWM; used only when PWM_SYNC_EN is defined.

Ports:
- clk  input  1  system sampling clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset; sampled on rising clk.
- meas_en  input  1  1 = measure; 0 = force IDLE and hold outputs.
- H_PWM  input  1  high-side PWM under measurement.
- L_PWM  input  1  low-side PWM under measurement.
- H_on_meas  output  Dc_length  cycles H sampled high.
- DT_HL_meas  output  Dc_length  cycles from H fall to L rise.
- L_on_meas  output  Dc_length  cycles L sampled high.
- DT_LH_meas  output  Dc_length  cycles from L fall to the next H rise.
- Period_meas  output  Dc_length+2  sum of the four phases, zero-extended, no overflow.
- meas_valid  output  1  one-cycle strobe; the five values above were updated this cycle.
- meas_sat  output  1  qualifies meas_valid; at least one phase saturated in this set.
- overlap_err  output  1  one-cycle pulse; H and L sampled high together.
- seq_err  output  1  one-cycle pulse; illegal edge order.

Behaviour:
- Reset (rst=0 at a clk edge):
  - All outputs 0; state IDLE; counter 0; sample/previous registers 0.
- Sampling and edge detection:
  - sH and sL are the registered (or synchronised) inputs; pH and pL are their one-cycle-delayed copies.
  - rise = s & ~p; fall = ~s & p.
- Counting convention:
  - Entering a state loads cnt = 1; each further cycle in that state increments cnt.
  - cnt saturates at 2^Dc_length-1 and sets an internal sat sticky bit, which clears on publish or on entering IDLE.
- States and transitions:
  - IDLE: on H rise with sL=0, go H_ON (cnt=1). All other inputs: stay.
  - H_ON: on H fall with sL=0, store h=cnt and go DT_HL. On H fall with L rise in the same cycle, store h, store dthl=0 and go L_ON.
  - DT_HL: on L rise, store dthl=cnt and go L_ON. On H rise, pulse seq_err and go H_ON (cnt=1), discarding partials.
  - L_ON: on L fall, store l=cnt and go DT_LH. On L fall with H rise in the same cycle, store l, set dtlh=0 and publish.
  - DT_LH: on H rise, store dtlh=cnt, publish, go H_ON (cnt=1). On L rise, pulse seq_err and go IDLE.
- Overlap:
  - sH=1 and sL=1 in any state: pulse overlap_err, go IDLE, no publish.
  - Overlap takes priority over every other transition.
- Publish (registered):
  - In the cycle after the closing H rise is seen, the four phase outputs, Period_meas, meas_sat and meas_valid=1 update together.
  - meas_valid is high for exactly one cycle.
  - Outputs hold until the next publish.
- meas_en=0:
  - Next state IDLE, partials discarded, no strobes.
  - Outputs hold their last values.
  - Measurement restarts at the first H rise after meas_en returns to 1.
- Latency from a pin edge to its detection:
  - 1 cycle without PWM_SYNC_EN.
  - SYNC_STAGES+1 cycles with it.
  - Measured widths are identical in both cases.
- The first period after reset or IDLE starts at an H rise; the partial period preceding it is never published.

Optional Feature:
- Macro: PWM_SYNC_EN.
- Defined: H_PWM and L_PWM each pass through a SYNC_STAGES-deep flop chain before edge detection, for asynchronous DPWM outputs.
- Undefined: a single sampling register per input; the inputs must be synchronous to clk.

Test Plan:
- Reset, then H high 10 cycles, gap 3, L high 20, gap 4, H rise -> H_on=10, DT_HL=3, L_on=20, DT_LH=4, Period=37, meas_valid 1 cycle, meas_sat=0.
- H fall and L rise in the same cycle, with L_on=5 and DT_LH=2 -> DT_HL=0, Period=H_on+7, no errors.
- H and L both high for 1 cycle during L_ON -> overlap_err 1 cycle, no meas_valid; the next clean period publishes correct values.
- H high 3, low 2, H rises again with no L pulse -> seq_err pulse; measurement resumes from the new H rise.
- Dc_length=4, H high 20 cycles -> H_on=15, meas_sat=1 with the next meas_valid.
- rst=0 for 1 cycle mid L_ON, and separately meas_en=0 mid period -> after reset all outputs 0; after meas_en drop the previous outputs hold and no strobe occurs until a full new period completes.
